// File: rtl/enigma_rotor_stack_if.sv
// Key/config/result bundle of the rotor stack scrambler core.
// The master side is the keyboard/plugboard stage; the slave side is the rotor stack.
interface enigma_rotor_stack_if #(
  parameter int N_ROTORS = 3
);
  logic                  key_valid;
  logic [25:0]           key_in;
  logic                  key_ready;
  logic                  load_valid;
  logic [5*N_ROTORS-1:0] load_pos;
  logic [5*N_ROTORS-1:0] load_ring;
  logic [2*N_ROTORS-1:0] load_type;
  logic                  out_valid;
  logic [25:0]           out_code;
  logic                  out_err;
  logic [5*N_ROTORS-1:0] pos_out;

  modport master (
    output key_valid, key_in, load_valid, load_pos, load_ring, load_type,
    input  key_ready, out_valid, out_code, out_err, pos_out
  );

  modport slave (
    input  key_valid, key_in, load_valid, load_pos, load_ring, load_type,
    output key_ready, out_valid, out_code, out_err, pos_out
  );
endinterface

// File: rtl/enigma_rotor_stack.sv
// Chain of N_ROTORS stepping rotors plus reflector; one letter per accepted key,
// stepping and encoding happen on the same edge, result registered (latency 1).
module enigma_rotor_stack #(
  parameter int N_ROTORS = 3
) (
  input  logic                clk,
  input  logic                resetn,
  enigma_rotor_stack_if.slave io
);

  // Tables stored as ASCII strings; character i is the image of letter i.
  localparam logic [8*26-1:0] WIRE0 = "VTYJLGPNWEFKCQXRUAHMBOZDSI";
  localparam logic [8*26-1:0] WIRE1 = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [8*26-1:0] WIRE2 = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [8*26-1:0] WIRE3 = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  localparam logic [8*26-1:0] REFL  = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  function automatic logic [4:0] tab_char(input logic [8*26-1:0] tab, input logic [4:0] i);
    logic [7:0] ch;
    ch = tab[8*(25-int'(i)) +: 8];
    return 5'(ch - 8'd65);
  endfunction

  function automatic logic [4:0] wire_fwd(input logic [1:0] t, input logic [4:0] i);
    logic [4:0] r;
    case (t)
      2'd0:    r = tab_char(WIRE0, i);
      2'd1:    r = tab_char(WIRE1, i);
      2'd2:    r = tab_char(WIRE2, i);
      default: r = tab_char(WIRE3, i);
    endcase
    return r;
  endfunction

  function automatic logic [4:0] wire_inv(input logic [1:0] t, input logic [4:0] y);
    logic [4:0] r;
    r = '0;
    for (int j = 0; j < 26; j++) begin
      if (wire_fwd(t, 5'(j)) == y) r = 5'(j);
    end
    return r;
  endfunction

  function automatic logic [4:0] notch_of(input logic [1:0] t);
    logic [4:0] r;
    case (t)
      2'd0:    r = 5'd25;
      2'd1:    r = 5'd16;
      2'd2:    r = 5'd4;
      default: r = 5'd21;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
  endfunction

  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    return (a >= b) ? 5'(a - b) : 5'(a + 5'd26 - b);
  endfunction

  function automatic logic [4:0] clamp25(input logic [4:0] v);
    return (v > 5'd25) ? 5'd0 : v;
  endfunction

  logic [4:0]          pos_reg  [N_ROTORS];
  logic [4:0]          ring_reg [N_ROTORS];
  logic [1:0]          type_reg [N_ROTORS];
  logic [4:0]          pos_next [N_ROTORS];
  logic [4:0]          shift    [N_ROTORS];
  logic [4:0]          fwd_c    [N_ROTORS+1];
  logic [4:0]          rev_c    [N_ROTORS+1];
  logic [N_ROTORS-1:0] at_notch;
  logic [N_ROTORS-1:0] step;
  logic                out_valid_reg;
  logic [25:0]         out_code_reg;
  logic                out_err_reg;
  logic [4:0]          key_idx;
  logic                key_onehot;
  logic                accept;

  assign io.key_ready = ~io.load_valid;
  assign accept       = io.key_valid & ~io.load_valid;
  assign key_onehot   = $onehot(io.key_in);

  always_comb begin
    key_idx = '0;
    for (int i = 0; i < 26; i++) begin
      if (io.key_in[i]) key_idx = 5'(i);
    end
  end

  assign fwd_c[0]        = key_idx;
  assign rev_c[N_ROTORS] = tab_char(REFL, fwd_c[N_ROTORS]);

  genvar gi;
  generate
    for (gi = 0; gi < N_ROTORS; gi++) begin : g_slot
      assign at_notch[gi] = (pos_reg[gi] == notch_of(type_reg[gi]));
      // Middle slots also step off their own notch (the double-step anomaly).
      if (gi == 0) begin : g_fast
        assign step[gi] = 1'b1;
      end else if (gi <= N_ROTORS - 2) begin : g_mid
        assign step[gi] = at_notch[gi-1] | at_notch[gi];
      end else begin : g_last
        assign step[gi] = at_notch[gi-1];
      end
      assign pos_next[gi] = step[gi] ? add26(pos_reg[gi], 5'd1) : pos_reg[gi];
      assign shift[gi]    = sub26(pos_next[gi], ring_reg[gi]);
      assign fwd_c[gi+1]  = sub26(wire_fwd(type_reg[gi], add26(fwd_c[gi], shift[gi])), shift[gi]);
      assign rev_c[gi]    = sub26(wire_inv(type_reg[gi], add26(rev_c[gi+1], shift[gi])), shift[gi]);
      assign io.pos_out[5*gi +: 5] = pos_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < N_ROTORS; k++) begin
        pos_reg[k]  <= '0;
        ring_reg[k] <= '0;
        type_reg[k] <= '0;
      end
      out_valid_reg <= 1'b0;
      out_code_reg  <= '0;
      out_err_reg   <= 1'b0;
    end else begin
      out_valid_reg <= accept;
      out_err_reg   <= accept & ~key_onehot;
      if (io.load_valid) begin
        for (int k = 0; k < N_ROTORS; k++) begin
          pos_reg[k]  <= clamp25(io.load_pos[5*k +: 5]);
          ring_reg[k] <= clamp25(io.load_ring[5*k +: 5]);
          type_reg[k] <= io.load_type[2*k +: 2];
        end
      end else if (accept) begin
        for (int k = 0; k < N_ROTORS; k++) begin
          pos_reg[k] <= pos_next[k];
        end
        out_code_reg <= key_onehot ? (26'd1 << rev_c[0]) : 26'd0;
      end
    end
  end

  assign io.out_valid = out_valid_reg;
  assign io.out_code  = out_code_reg;
  assign io.out_err   = out_err_reg;

endmodule
